// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-phase core front end: phase bit indices,
// opcode bytes, fetch-sequencer state encoding and instruction-length width.
package cpu_pkg;

    localparam int NPHASE = 5;
    localparam int F_B    = 0;
    localparam int R_B    = 1;
    localparam int X_B    = 2;
    localparam int M_B    = 3;
    localparam int W_B    = 4;

    localparam int LEN_W  = 2;

    localparam logic [7:0] OPC_LD   = 8'h8B;
    localparam logic [7:0] OPC_MOV  = 8'h89;
    localparam logic [7:0] OPC_ADD  = 8'h01;
    localparam logic [7:0] OPC_SUB  = 8'h29;
    localparam logic [7:0] OPC_CMP  = 8'h39;
    localparam logic [7:0] OPC_AND  = 8'h21;
    localparam logic [7:0] OPC_OR   = 8'h09;
    localparam logic [7:0] OPC_XOR  = 8'h31;
    localparam logic [7:0] OPC_GRP3 = 8'hF7;
    localparam logic [7:0] OPC_PFX  = 8'h66;
    localparam logic [7:0] OPC_GRP1 = 8'h83;
    localparam logic [7:0] OPC_SHI  = 8'hC1;
    localparam logic [7:0] OPC_NOP  = 8'h90;
    localparam logic [7:0] OPC_HLT  = 8'hF4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_F    = 3'd1,
        ST_R    = 3'd2,
        ST_X    = 3'd3,
        ST_M    = 3'd4,
        ST_W    = 3'd5,
        ST_HALT = 3'd6
    } state_e;

    // IDLE and HALT present an all-zero phase vector.
    function automatic logic [NPHASE-1:0] phase_of(input state_e s);
        logic [NPHASE-1:0] p;
        p = '0;
        case (s)
            ST_F:    p[F_B] = 1'b1;
            ST_R:    p[R_B] = 1'b1;
            ST_X:    p[X_B] = 1'b1;
            ST_M:    p[M_B] = 1'b1;
            ST_W:    p[W_B] = 1'b1;
            default: p      = '0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/insn_len.sv
// Combinational opcode-byte decoder: instruction length in bytes plus a flag
// telling whether the opcode is one the core knows.
module insn_len
    import cpu_pkg::*;
(
    input  logic [7:0]       opcode,
    output logic [LEN_W-1:0] len,
    output logic             known
);

    // NOTE: every output gets a default before the case so no path leaves a
    // value unassigned; a missing default here would infer a latch.
    always_comb begin
        len   = 2'd1;
        known = 1'b0;
        case (opcode)
            OPC_LD, OPC_MOV, OPC_ADD, OPC_SUB, OPC_CMP,
            OPC_AND, OPC_OR, OPC_XOR, OPC_GRP3: begin
                len   = 2'd2;
                known = 1'b1;
            end
            OPC_PFX, OPC_GRP1, OPC_SHI, OPC_NOP: begin
                len   = 2'd3;
                known = 1'b1;
            end
            OPC_HLT: begin
                len   = 2'd1;
                known = 1'b1;
            end
            default: begin
                len   = 2'd1;
                known = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Front end of the multi-phase core: PC, instruction fetch over req/ack, phase
// sequencing, branch redirect and halt. `ILLEGAL_TRAP_EN enables the unknown-opcode trap.
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int            AW       = 32,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [AW-1:0]     imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic              cr_taken,
    input  logic [AW-1:0]     br_target,
    input  logic              halt,
    output logic [31:0]       ir,
    output logic [NPHASE-1:0] phase,
    output logic [AW-1:0]     pc,
    output logic              halted,
    output logic [31:0]       retired,
    output logic              illegal
);

    state_e            state_q, state_d;
    logic [AW-1:0]     pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [31:0]       retired_q, retired_d;
    logic              ill_d;
    logic [LEN_W-1:0]  op_len;
    logic              op_known;

    insn_len u_insn_len (
        .opcode (ir_q[31:24]),
        .len    (op_len),
        .known  (op_known)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        retired_d = retired_q;
        ill_d     = 1'b0;
        case (state_q)
            ST_IDLE: state_d = ST_F;
            ST_F: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = ST_R;
                end
            end
            ST_R: state_d = ST_X;
            ST_X: state_d = ST_M;
            ST_M: state_d = ST_W;
            ST_W: begin
                state_d = ST_F;
                if (halt) begin
                    state_d   = ST_HALT;
                    retired_d = retired_q + 32'd1;
                end
`ifdef ILLEGAL_TRAP_EN
                else if (!op_known) begin
                    state_d = ST_HALT;
                    ill_d   = 1'b1;
                end
`endif
                else if (cr_taken) begin
                    pc_d      = br_target;
                    retired_d = retired_q + 32'd1;
                end else begin
                    pc_d      = pc_q + {{(AW-LEN_W){1'b0}}, op_len};
                    retired_d = retired_q + 32'd1;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
        end
    end

`ifdef ILLEGAL_TRAP_EN
    logic ill_q;

    // Sticky until reset, like the HALT state it accompanies.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ill_q <= 1'b0;
        end else if (ill_d) begin
            ill_q <= 1'b1;
        end
    end

    assign illegal = ill_q;
`else
    logic unused_trap;
    assign unused_trap = op_known ^ ill_d;
    assign illegal     = 1'b0;
`endif

    assign imem_req  = (state_q == ST_F);
    assign imem_addr = pc_q;
    assign phase     = phase_of(state_q);
    assign pc        = pc_q;
    assign ir        = ir_q;
    assign halted    = (state_q == ST_HALT);
    assign retired   = retired_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: expected fetch handshakes go into a
// scoreboard queue drained by a monitor; phase/pc/ir checks are inline.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        cr_taken;
    logic [31:0] br_target;
    logic        halt;
    logic [31:0] ir;
    logic [4:0]  phase;
    logic [31:0] pc;
    logic        halted;
    logic [31:0] retired;
    logic        illegal;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] ret;
    } fetch_exp_t;

    fetch_exp_t  sb_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] last_ir;

    fetch_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .cr_taken   (cr_taken),
        .br_target  (br_target),
        .halt       (halt),
        .ir         (ir),
        .phase      (phase),
        .pc         (pc),
        .halted     (halted),
        .retired    (retired),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted fetch handshake must match the next expected fetch.
    always @(negedge clk) begin
        if (rst_n && imem_req && imem_ack) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL fetch_unexpected: got addr %h, expected no fetch (t=%0t)", imem_addr, $time);
            end else begin
                fetch_exp_t e;
                e = sb_q.pop_front();
                check("fetch_addr", imem_addr, e.addr);
                check("fetch_retired", retired, e.ret);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state();
        check("rst_phase", {27'd0, phase}, 32'd0);
        check("rst_pc", pc, 32'd0);
        check("rst_ir", ir, 32'd0);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_retired", retired, 32'd0);
        check("rst_illegal", {31'd0, illegal}, 32'd0);
    endtask

    // Leaves the DUT in IDLE with reset released; next tick enters F.
    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        check_reset_state();
        last_ir = 32'd0;
        rst_n   = 1'b1;
    endtask

    // Runs one instruction starting in F: fetch with ack delay, R/X/M/W, W exit.
    task automatic run_insn(input logic [31:0] word, input int delay,
                            input logic h, input logic c, input logic [31:0] tgt,
                            input logic [31:0] exp_addr, input logic [31:0] exp_ret_before,
                            input logic [31:0] exp_pc_after, input logic [31:0] exp_ret_after,
                            input logic exp_halt, input logic exp_ill);
        sb_q.push_back('{addr: exp_addr, ret: exp_ret_before});
        check("f_phase", {27'd0, phase}, 32'h01);
        check("f_req", {31'd0, imem_req}, 32'd1);
        check("f_addr", imem_addr, exp_addr);
        for (int i = 0; i < delay; i++) begin
            imem_ack   = 1'b0;
            imem_rdata = ~word;
            tick();
            check("wait_phase", {27'd0, phase}, 32'h01);
            check("wait_req", {31'd0, imem_req}, 32'd1);
            check("wait_addr", imem_addr, exp_addr);
            check("wait_ir", ir, last_ir);
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        check("r_phase", {27'd0, phase}, 32'h02);
        check("r_ir", ir, word);
        check("r_pc", pc, exp_addr);
        check("r_req", {31'd0, imem_req}, 32'd0);
        tick();
        check("x_phase", {27'd0, phase}, 32'h04);
        tick();
        check("m_phase", {27'd0, phase}, 32'h08);
        tick();
        check("w_phase", {27'd0, phase}, 32'h10);
        halt      = h;
        cr_taken  = c;
        br_target = tgt;
        tick();
        halt      = 1'b0;
        cr_taken  = 1'b0;
        br_target = 32'd0;
        last_ir   = word;
        check("exit_pc", pc, exp_pc_after);
        check("exit_retired", retired, exp_ret_after);
        check("exit_halted", {31'd0, halted}, {31'd0, exp_halt});
        check("exit_illegal", {31'd0, illegal}, {31'd0, exp_ill});
        check("exit_phase", {27'd0, phase}, exp_halt ? 32'h00 : 32'h01);
        check("exit_req", {31'd0, imem_req}, exp_halt ? 32'd0 : 32'd1);
        check("exit_ir", ir, word);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        cr_taken   = 1'b0;
        br_target  = 32'd0;
        halt       = 1'b0;
        last_ir    = 32'd0;

        do_reset();
        tick();
        // ADD at 0, ack on first F cycle: len 2.
        run_insn(32'h01C0_0000, 0, 1'b0, 1'b0, 32'h0, 32'h0, 32'd0, 32'h2, 32'd1, 1'b0, 1'b0);
        // NOP at 2, ack delayed 3 cycles, branch to 0x10.
        run_insn(32'h9000_0000, 3, 1'b0, 1'b1, 32'h10, 32'h2, 32'd1, 32'h10, 32'd2, 1'b0, 1'b0);
        // NOP at 0x10 taken to 0x40, back to 0x10, then not taken -> 0x13.
        run_insn(32'h9012_3456, 0, 1'b0, 1'b1, 32'h40, 32'h10, 32'd2, 32'h40, 32'd3, 1'b0, 1'b0);
        run_insn(32'h8B45_0000, 1, 1'b0, 1'b1, 32'h10, 32'h40, 32'd3, 32'h10, 32'd4, 1'b0, 1'b0);
        run_insn(32'h9000_0000, 0, 1'b0, 1'b0, 32'h0,  32'h10, 32'd4, 32'h13, 32'd5, 1'b0, 1'b0);
        // HLT with halt=1: stop, pc unchanged, retired counts it.
        run_insn(32'hF400_0000, 0, 1'b1, 1'b0, 32'h0,  32'h13, 32'd5, 32'h13, 32'd6, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            imem_ack  = 1'b1;
            cr_taken  = 1'b1;
            halt      = 1'b1;
            br_target = 32'h80;
            tick();
            check("halt_phase", {27'd0, phase}, 32'd0);
            check("halt_req", {31'd0, imem_req}, 32'd0);
            check("halt_retired", retired, 32'd6);
            check("halt_pc", pc, 32'h13);
            check("halt_sticky", {31'd0, halted}, 32'd1);
        end
        imem_ack  = 1'b0;
        cr_taken  = 1'b0;
        halt      = 1'b0;
        br_target = 32'd0;

        // Reset out of HALT, then abort a pending fetch with reset and a late ack.
        do_reset();
        tick();
        check("t5_req", {31'd0, imem_req}, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'h8B00_0000;
        check("t5_phase", {27'd0, phase}, 32'd0);
        check("t5_ir", ir, 32'd0);
        check("t5_pc", pc, 32'd0);
        check("t5_req_dropped", {31'd0, imem_req}, 32'd0);
        tick();
        imem_ack = 1'b0;
        check("t5_ir_after", ir, 32'd0);
        check("t5_phase_f", {27'd0, phase}, 32'h01);

        // Branch to the top of the address space, then a 2-byte insn wraps to 1.
        run_insn(32'h0100_0000, 0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0, 32'd0, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        run_insn(32'h2900_0000, 0, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFF, 32'd1, 32'h1, 32'd2, 1'b0, 1'b0);
        run_insn(32'h6600_0000, 1, 1'b0, 1'b0, 32'h0, 32'h1, 32'd2, 32'h4, 32'd3, 1'b0, 1'b0);
`ifdef ILLEGAL_TRAP_EN
        run_insn(32'hAA00_0000, 0, 1'b0, 1'b1, 32'h80, 32'h4, 32'd3, 32'h4, 32'd3, 1'b1, 1'b1);
        do_reset();
        tick();
        run_insn(32'hF400_0000, 0, 1'b1, 1'b1, 32'h80, 32'h0, 32'd0, 32'h0, 32'd1, 1'b1, 1'b0);
`else
        run_insn(32'hAA00_0000, 0, 1'b0, 1'b0, 32'h0, 32'h4, 32'd3, 32'h5, 32'd4, 1'b0, 1'b0);
        // halt and cr_taken together: halt wins, no redirect.
        run_insn(32'hF400_0000, 0, 1'b1, 1'b1, 32'h80, 32'h5, 32'd4, 32'h5, 32'd5, 1'b1, 1'b0);
`endif

        repeat (3) tick();
        check("sb_drained", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
